// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds a word RAM with
// byte-lane writes, and returns one registered response LATENCY edges after acceptance.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0]   mem_q [DEPTH];
  logic [3:0]    mem_we;
  logic [31:0]   wdata_al;
  logic [AW-1:0] idx_d;
  logic          go_resp;
  logic          err;

  // Right-justify the addressed lane(s) and extend; word loads pass through untouched.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sign);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    r  = word;
    case (size)
      2'b00: if (sign) r = 32'(b); else r = {24'b0, sh[7:0]};
      2'b01: if (sign) r = 32'(h); else r = {16'b0, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    sign_d       = sign_q;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    mem_we       = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          sign_d  = req_sign;
          cnt_d   = LAT_M1;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase

    // Checks use the _d view so a latency-1 request is judged on the edge that latches it.
    idx_d    = addr_d[AW+1:2];
    wdata_al = (size_d == 2'b00) ? {4{wdata_d[7:0]}} :
               (size_d == 2'b01) ? {2{wdata_d[15:0]}} : wdata_d;
    err      = (size_d == 2'b11) ||
               (size_d == 2'b01 && addr_d[0]) ||
               (size_d == 2'b10 && addr_d[1:0] != 2'b00) ||
               ((addr_d >> (AW + 2)) != 32'h0);
    go_resp  = (state_d == RESP) && (state_q != RESP) && !reset;

    if (go_resp) begin
      if (err) resp_err_d = 1'b1;
      else if (write_d) mem_we = lane_mask(size_d, addr_d[1:0]);
      else resp_rdata_d = extend_load(mem_q[idx_d], addr_d[1:0], size_d, sign_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    write_q <= write_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    sign_q  <= sign_d;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem_q[idx_d][8*i +: 8] <= wdata_al[8*i +: 8];
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
